// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, parity codes and the baud divider derivation.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam int unsigned CHK_NONE = 0;
  localparam int unsigned CHK_ODD  = 1;
  localparam int unsigned CHK_EVEN = 2;

  // Clock cycles per bit time; callers must keep the ratio an integer >= 4.
  function automatic int unsigned calc_div(input int unsigned clk_freq, input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-time counter: free-runs 0..P_DIV-1 while not cleared, with registered mid-bit and end-of-bit strobes.
module uart_baud_cnt #(
  parameter int unsigned P_DIV = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  output logic o_mid,
  output logic o_end
);

  localparam int unsigned CNT_W = $clog2(P_DIV);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(P_DIV >> 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(P_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] cnt_next;

  // Strobes are registered from the next count so they line up with r_cnt itself.
  always_comb begin
    cnt_next = r_cnt + CNT_W'(1);
    if (i_clr || (r_cnt == CNT_LAST)) begin
      cnt_next = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
      o_mid <= 1'b0;
      o_end <= 1'b0;
    end else begin
      r_cnt <= cnt_next;
      o_mid <= (cnt_next == CNT_MID);
      o_end <= (cnt_next == CNT_LAST);
    end
  end

endmodule

// File: rtl/uart_rx_module.sv
// UART receiver: synchronises the serial line, deserialises one frame at a time on i_clk and
// presents each word as a one-cycle valid pulse with a parity/framing error flag.
module uart_rx_module
  import uart_pkg::*;
#(
  parameter int unsigned P_CLK_FREQ   = 50_000_000,
  parameter int unsigned P_BAUD_RATE  = 9600,
  parameter int unsigned P_DATA_WIDTH = 8,
  parameter int unsigned P_STOP_WIDTH = 1,
  parameter int unsigned P_CHECK      = 0
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_uart_rx,
  output logic [P_DATA_WIDTH-1:0] o_user_rx_data,
  output logic                    o_user_rx_valid,
  output logic                    o_user_rx_err
);

  localparam int unsigned P_DIV = calc_div(P_CLK_FREQ, P_BAUD_RATE);
  localparam int unsigned IDX_W = $clog2(P_DATA_WIDTH + 1);
  localparam logic [IDX_W-1:0] IDX_DATA_LAST = IDX_W'(P_DATA_WIDTH);
  localparam logic [IDX_W-1:0] IDX_STOP_LAST = IDX_W'(P_STOP_WIDTH - 1);
  localparam logic             PAR_ODD       = (P_CHECK == CHK_ODD);
  localparam logic             HAS_PARITY    = (P_CHECK != CHK_NONE);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic fall;

  state_t                  r_state;
  logic [IDX_W-1:0]        r_idx;
  logic [P_DATA_WIDTH-1:0] r_shift;
  logic                    r_err_p;
  logic                    r_err_f;

  logic cnt_clr;
  logic bit_mid;
  logic bit_end;

  // Two-flop synchroniser plus history flop for falling-edge detection.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= i_uart_rx;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign fall    = r_prev & ~r_sync2;
  assign cnt_clr = (r_state == ST_IDLE);

  uart_baud_cnt #(
    .P_DIV (P_DIV)
  ) u_baud_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (cnt_clr),
    .o_mid (bit_mid),
    .o_end (bit_end)
  );

  // Frame FSM; STOP leaves at the last stop-bit sample point so a back-to-back start edge is caught.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state         <= ST_IDLE;
      r_idx           <= '0;
      r_shift         <= '0;
      r_err_p         <= 1'b0;
      r_err_f         <= 1'b0;
      o_user_rx_data  <= '0;
      o_user_rx_valid <= 1'b0;
      o_user_rx_err   <= 1'b0;
    end else begin
      o_user_rx_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (fall) begin
            r_state <= ST_START;
            r_idx   <= '0;
            r_err_p <= 1'b0;
            r_err_f <= 1'b0;
          end
        end
        ST_START: begin
          if (bit_mid && r_sync2) begin
            r_state <= ST_IDLE;
          end else if (bit_end) begin
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_mid) begin
            r_shift <= {r_sync2, r_shift[P_DATA_WIDTH-1:1]};
            r_idx   <= r_idx + IDX_W'(1);
          end
          if (bit_end && (r_idx == IDX_DATA_LAST)) begin
            r_idx   <= '0;
            r_state <= HAS_PARITY ? ST_PARITY : ST_STOP;
          end
        end
        ST_PARITY: begin
          if (bit_mid) begin
            r_err_p <= ((^r_shift) ^ r_sync2) != PAR_ODD;
          end
          if (bit_end) begin
            r_state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (bit_mid) begin
            if (!r_sync2) begin
              r_err_f <= 1'b1;
            end
            if (r_idx == IDX_STOP_LAST) begin
              r_state         <= ST_IDLE;
              o_user_rx_valid <= 1'b1;
              o_user_rx_data  <= r_shift;
              o_user_rx_err   <= r_err_p | r_err_f | ~r_sync2;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_module.sv
// Bench for uart_rx_module: two instances (no parity / even parity) fed directed frames; a scoreboard
// queue per instance is checked by a monitor that pops on every valid pulse.
module tb_uart_rx_module;

  localparam int unsigned LAT_NOPAR = 156;
  localparam int unsigned LAT_PAR   = 172;

  typedef struct {
    logic [7:0]  data;
    logic        err;
    int unsigned t0;
    int unsigned lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst0, rst2;
  logic       rx0, rx2;
  logic [7:0] data0, data2;
  logic       v0, v2, e0, e2;

  exp_t        q0[$];
  exp_t        q2[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_module #(
    .P_CLK_FREQ(16), .P_BAUD_RATE(1), .P_DATA_WIDTH(8), .P_STOP_WIDTH(1), .P_CHECK(0)
  ) dut0 (
    .i_clk(clk), .i_rst(rst0), .i_uart_rx(rx0),
    .o_user_rx_data(data0), .o_user_rx_valid(v0), .o_user_rx_err(e0)
  );

  uart_rx_module #(
    .P_CLK_FREQ(16), .P_BAUD_RATE(1), .P_DATA_WIDTH(8), .P_STOP_WIDTH(1), .P_CHECK(2)
  ) dut2 (
    .i_clk(clk), .i_rst(rst2), .i_uart_rx(rx2),
    .o_user_rx_data(data2), .o_user_rx_valid(v2), .o_user_rx_err(e2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input int sel, input logic b);
    if (sel == 0) rx0 = b;
    else          rx2 = b;
  endtask

  task automatic hold_bit();
    repeat (16) @(negedge clk);
  endtask

  // Sends one frame starting at the current negedge and queues the response it should produce.
  task automatic send(input int sel, input logic [7:0] d, input bit has_par, input logic par,
                      input logic stop, input logic exp_err);
    exp_t e;
    e.data = d;
    e.err  = exp_err;
    e.t0   = cyc;
    e.lat  = has_par ? LAT_PAR : LAT_NOPAR;
    if (sel == 0) q0.push_back(e);
    else          q2.push_back(e);
    drive(sel, 1'b0);
    hold_bit();
    for (int i = 0; i < 8; i++) begin
      drive(sel, d[i]);
      hold_bit();
    end
    if (has_par) begin
      drive(sel, par);
      hold_bit();
    end
    drive(sel, stop);
    hold_bit();
  endtask

  task automatic mon(input int sel, input logic [7:0] d, input logic er);
    exp_t e;
    string tag;
    tag = (sel == 0) ? "dut0" : "dut2";
    if ((sel == 0 && q0.size() == 0) || (sel != 0 && q2.size() == 0)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s unexpected valid: got data 0x%0h err %0b, expected no valid", tag, d, er);
    end else begin
      e = (sel == 0) ? q0.pop_front() : q2.pop_front();
      chk({tag, " data"}, 32'(d), 32'(e.data));
      chk({tag, " err"}, 32'(er), 32'(e.err));
      chk({tag, " latency"}, cyc - e.t0, e.lat);
    end
  endtask

  initial begin
    rst0 = 1'b1;
    rst2 = 1'b1;
    rx0  = 1'b1;
    rx2  = 1'b1;
    repeat (4) @(negedge clk);
    rst0 = 1'b0;
    rst2 = 1'b0;
    @(negedge clk);
    chk("reset dut0 valid", 32'(v0), 0);
    chk("reset dut0 data", 32'(data0), 0);
    chk("reset dut0 err", 32'(e0), 0);
    chk("reset dut2 valid", 32'(v2), 0);
    chk("reset dut2 data", 32'(data2), 0);
    chk("reset dut2 err", 32'(e2), 0);

    fork
      forever begin
        @(negedge clk);
        if (v0) mon(0, data0, e0);
        if (v2) mon(2, data2, e2);
      end
    join_none

    repeat (8) @(negedge clk);

    // Plain frame, then idle.
    send(0, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(0, 1'b1);
    repeat (40) @(negedge clk);

    // Even parity: correct then wrong parity bit (0xA3 has four ones).
    send(2, 8'hA3, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(2, 1'b1);
    repeat (20) @(negedge clk);
    send(2, 8'hA3, 1'b1, 1'b1, 1'b1, 1'b1);
    drive(2, 1'b1);
    repeat (20) @(negedge clk);

    // Short glitch must be rejected, then a good frame.
    drive(0, 1'b0);
    repeat (5) @(negedge clk);
    drive(0, 1'b1);
    repeat (40) @(negedge clk);
    send(0, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(0, 1'b1);
    repeat (20) @(negedge clk);

    // Framing error, then a good frame.
    send(0, 8'h81, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(0, 1'b1);
    repeat (20) @(negedge clk);
    send(0, 8'h7E, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(0, 1'b1);
    repeat (20) @(negedge clk);

    // Back-to-back frames with no idle gap.
    send(0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    send(0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(0, 1'b1);
    repeat (20) @(negedge clk);

    // Reset after start + 4 data bits of 0xF0 (all zero so far); partial frame must vanish.
    drive(0, 1'b0);
    repeat (80) @(negedge clk);
    drive(0, 1'b1);
    rst0 = 1'b1;
    repeat (2) @(negedge clk);
    rst0 = 1'b0;
    chk("midreset dut0 valid", 32'(v0), 0);
    chk("midreset dut0 data", 32'(data0), 0);
    chk("midreset dut0 err", 32'(e0), 0);
    repeat (20) @(negedge clk);
    send(0, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(0, 1'b1);

    // Bounded drain, then a quiet period to catch stray pulses.
    for (int i = 0; i < 400; i++) begin
      if (q0.size() == 0 && q2.size() == 0) break;
      @(negedge clk);
    end
    chk("dut0 pending frames", 32'(q0.size()), 0);
    chk("dut2 pending frames", 32'(q2.size()), 0);
    repeat (200) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
